// File: rtl/lfsr_seq_checker_pkg.sv
// Shared definitions for the M-sequence receive checker: default tap mask,
// checker state encoding and the LFSR successor rule used by source and sink.
package lfsr_seq_checker_pkg;

    localparam logic [31:0] LFSR_FEEDBACK = 32'h0028_0c97;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } chk_state_t;

    function automatic logic [31:0] lfsr_next(input logic [31:0] x, input logic [31:0] mask);
        return {^(mask & x), x[31:1]};
    endfunction

endpackage

// File: rtl/lfsr_seq_checker_popcount32.sv
// Combinational population count of a 32-bit word; gives the bit-error
// weight of a mismatched word.
module lfsr_seq_checker_popcount32 (
    input  logic [31:0] bits,
    output logic [5:0]  count
);

    always_comb begin
        count = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            count = count + 6'(bits[i]);
        end
    end

endmodule

// File: rtl/lfsr_seq_checker.sv
// Receive-side checker for the 32-bit M-sequence source: hunts, syncs and
// flywheels on the LFSR successor rule, reporting lock and error counts.
module lfsr_seq_checker
    import lfsr_seq_checker_pkg::*;
#(
    parameter logic [31:0] FEEDBACK    = LFSR_FEEDBACK,
    parameter int unsigned LOCK_CNT    = 4,
    parameter int unsigned UNLOCK_ERRS = 3,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    input  logic [31:0]      in_code,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] word_err_cnt,
    output logic [CNT_W-1:0] bit_err_cnt,
    output logic [31:0]      word_cnt
);

    localparam int unsigned MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int unsigned MISS_W  = $clog2(UNLOCK_ERRS + 1);

    chk_state_t         state;
    logic [31:0]        pred;
    logic [MATCH_W-1:0] match_cnt;
    logic [MISS_W-1:0]  miss_cnt;

    logic [31:0]        diff;
    logic [5:0]         err_weight;
    logic               code_ok;
    logic               locked_word;
    logic               locked_err;
    logic [CNT_W:0]     bit_sum;

    assign diff        = in_code ^ pred;
    assign code_ok     = (in_code == pred);
    assign locked_word = in_valid && (state == LOCKED);
    assign locked_err  = locked_word && !code_ok;
    // Extra carry bit lets the clamp detect overflow of the weighted add.
    assign bit_sum     = {1'b0, bit_err_cnt} + (CNT_W + 1)'(err_weight);

    lfsr_seq_checker_popcount32 u_popcount (
        .bits  (diff),
        .count (err_weight)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= HUNT;
            pred      <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
        end else begin
            err_pulse <= 1'b0;
            if (in_valid) begin
                case (state)
                    HUNT: begin
                        // All-zero is the LFSR lock-up word and cannot seed.
                        if (in_code != '0) begin
                            pred      <= lfsr_next(in_code, FEEDBACK);
                            match_cnt <= '0;
                            state     <= SYNC;
                        end
                    end
                    SYNC: begin
                        pred <= lfsr_next(in_code, FEEDBACK);
                        if (code_ok) begin
                            if (match_cnt == MATCH_W'(LOCK_CNT - 1)) begin
                                state     <= LOCKED;
                                locked    <= 1'b1;
                                miss_cnt  <= '0;
                                match_cnt <= '0;
                            end else begin
                                match_cnt <= match_cnt + 1'b1;
                            end
                        end else begin
                            match_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        // Flywheel: received data never re-seeds the predictor.
                        pred <= lfsr_next(pred, FEEDBACK);
                        if (code_ok) begin
                            miss_cnt <= '0;
                        end else begin
                            err_pulse <= 1'b1;
                            if (miss_cnt == MISS_W'(UNLOCK_ERRS - 1)) begin
                                state    <= HUNT;
                                locked   <= 1'b0;
                                miss_cnt <= '0;
                            end else begin
                                miss_cnt <= miss_cnt + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state  <= HUNT;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            word_err_cnt <= '0;
            bit_err_cnt  <= '0;
            word_cnt     <= '0;
        end else if (clr_cnt) begin
            word_err_cnt <= '0;
            bit_err_cnt  <= '0;
            word_cnt     <= '0;
        end else begin
            if (locked_word) begin
                word_cnt <= word_cnt + 32'd1;
            end
            if (locked_err) begin
                if (word_err_cnt != '1) begin
                    word_err_cnt <= word_err_cnt + 1'b1;
                end
                bit_err_cnt <= bit_sum[CNT_W] ? '1 : bit_sum[CNT_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Directed self-checking bench for lfsr_seq_checker; a second narrow-counter
// instance exercises counter saturation in a short run.
module tb_lfsr_seq_checker;

    localparam logic [31:0] FB = 32'h0028_0c97;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_code = '0;
    logic        clr_cnt = 1'b0;
    logic        locked, err_pulse;
    logic [15:0] word_err_cnt, bit_err_cnt;
    logic [31:0] word_cnt;

    logic        v2 = 1'b0;
    logic [31:0] code2 = '0;
    logic        clr2 = 1'b0;
    logic        locked2, err2;
    logic [7:0]  werr2, berr2;
    logic [31:0] wcnt2;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_pred;
    logic [31:0] exp_pred2;
    logic [31:0] seq [5];

    always #5 clk = ~clk;

    lfsr_seq_checker dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_code(in_code), .clr_cnt(clr_cnt),
        .locked(locked), .err_pulse(err_pulse), .word_err_cnt(word_err_cnt),
        .bit_err_cnt(bit_err_cnt), .word_cnt(word_cnt)
    );

    lfsr_seq_checker #(.CNT_W(8)) dut_sat (
        .clk(clk), .rstn(rstn), .in_valid(v2), .in_code(code2), .clr_cnt(clr2),
        .locked(locked2), .err_pulse(err2), .word_err_cnt(werr2),
        .bit_err_cnt(berr2), .word_cnt(wcnt2)
    );

    function automatic logic [31:0] ref_next(input logic [31:0] x);
        logic fb;
        fb = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (FB[i]) fb = fb ^ x[i];
        end
        return {fb, x[31:1]};
    endfunction

    task automatic strobe(input logic [31:0] code);
        @(negedge clk);
        in_valid = 1'b1;
        in_code  = code;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic strobe2(input logic [31:0] code);
        @(negedge clk);
        v2    = 1'b1;
        code2 = code;
        @(negedge clk);
        v2    = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({locked, err_pulse, word_err_cnt, bit_err_cnt, word_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: locked=%0b err=%0b werr=%0d berr=%0d wcnt=%0d expected all 0",
                     locked, err_pulse, word_err_cnt, bit_err_cnt, word_cnt);
        end
        n_checks++;
        if ({locked2, err2, werr2, berr2, wcnt2} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs_sat: locked=%0b werr=%0d berr=%0d expected all 0", locked2, werr2, berr2);
        end
        rstn = 1'b1;
    endtask

    task automatic test_lock;
        for (int i = 0; i < 5; i++) begin
            strobe(seq[i]);
            n_checks++;
            if (locked !== (i == 4)) begin
                n_fail++;
                $display("FAIL lock_word%0d: locked=%0b expected %0b", i, locked, (i == 4));
            end
            n_checks++;
            if (err_pulse !== 1'b0) begin
                n_fail++;
                $display("FAIL lock_err_pulse%0d: err_pulse=%0b expected 0", i, err_pulse);
            end
            repeat (2) @(negedge clk);
        end
        n_checks++;
        if (word_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL lock_word_cnt: word_cnt=%0d expected 0", word_cnt);
        end
        exp_pred = 32'hc001_f668;
    endtask

    task automatic test_zero_error;
        strobe(32'h0);
        n_checks++;
        if ({err_pulse, locked, word_err_cnt, bit_err_cnt} !== {1'b1, 1'b1, 16'd1, 16'd12}) begin
            n_fail++;
            $display("FAIL zero_word_err: err=%0b locked=%0b werr=%0d berr=%0d expected 1 1 1 12",
                     err_pulse, locked, word_err_cnt, bit_err_cnt);
        end
        exp_pred = 32'he000_fb34;
        strobe(exp_pred);
        exp_pred = ref_next(exp_pred);
        n_checks++;
        if (err_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_word_pulse_once: err_pulse=%0b expected 0", err_pulse);
        end
        strobe(exp_pred);
        exp_pred = ref_next(exp_pred);
        n_checks++;
        if ({locked, word_err_cnt, bit_err_cnt, word_cnt} !== {1'b1, 16'd1, 16'd12, 32'd3}) begin
            n_fail++;
            $display("FAIL zero_word_hold: locked=%0b werr=%0d berr=%0d wcnt=%0d expected 1 1 12 3",
                     locked, word_err_cnt, bit_err_cnt, word_cnt);
        end
    endtask

    task automatic test_unlock_relock;
        @(negedge clk);
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        n_checks++;
        if ({locked, word_err_cnt, bit_err_cnt, word_cnt} !== {1'b1, 16'd0, 16'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL clr_cnt: locked=%0b werr=%0d berr=%0d wcnt=%0d expected 1 0 0 0",
                     locked, word_err_cnt, bit_err_cnt, word_cnt);
        end
        for (int k = 0; k < 3; k++) begin
            strobe(exp_pred ^ 32'h1);
            exp_pred = ref_next(exp_pred);
            n_checks++;
            if (locked !== (k < 2)) begin
                n_fail++;
                $display("FAIL unlock_err%0d: locked=%0b expected %0b", k, locked, (k < 2));
            end
        end
        n_checks++;
        if ({word_err_cnt, bit_err_cnt, word_cnt} !== {16'd3, 16'd3, 32'd3}) begin
            n_fail++;
            $display("FAIL unlock_counts: werr=%0d berr=%0d wcnt=%0d expected 3 3 3",
                     word_err_cnt, bit_err_cnt, word_cnt);
        end
        for (int k = 0; k < 5; k++) begin
            strobe(exp_pred);
            exp_pred = ref_next(exp_pred);
            n_checks++;
            if (locked !== (k == 4)) begin
                n_fail++;
                $display("FAIL relock_word%0d: locked=%0b expected %0b", k, locked, (k == 4));
            end
        end
    endtask

    task automatic test_async_reset;
        strobe(exp_pred);
        exp_pred = ref_next(exp_pred);
        n_checks++;
        if (word_cnt !== 32'd4) begin
            n_fail++;
            $display("FAIL pre_reset_word_cnt: word_cnt=%0d expected 4", word_cnt);
        end
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        n_checks++;
        if ({locked, word_err_cnt, bit_err_cnt, word_cnt} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: locked=%0b werr=%0d berr=%0d wcnt=%0d expected all 0",
                     locked, word_err_cnt, bit_err_cnt, word_cnt);
        end
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            strobe(seq[i]);
            n_checks++;
            if (locked !== (i == 4)) begin
                n_fail++;
                $display("FAIL post_reset_lock%0d: locked=%0b expected %0b", i, locked, (i == 4));
            end
        end
        exp_pred = 32'hc001_f668;
    endtask

    task automatic test_zero_hunt;
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            strobe(32'h0);
            n_checks++;
            if ({locked, err_pulse} !== 2'b00) begin
                n_fail++;
                $display("FAIL zero_hunt%0d: locked=%0b err=%0b expected 0 0", i, locked, err_pulse);
            end
        end
        n_checks++;
        if ({word_err_cnt, bit_err_cnt, word_cnt} !== '0) begin
            n_fail++;
            $display("FAIL zero_hunt_counts: werr=%0d berr=%0d wcnt=%0d expected 0 0 0",
                     word_err_cnt, bit_err_cnt, word_cnt);
        end
        for (int i = 0; i < 5; i++) begin
            strobe(seq[i]);
        end
        n_checks++;
        if (locked !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_hunt_relock: locked=%0b expected 1", locked);
        end
    endtask

    task automatic test_saturation;
        for (int i = 0; i < 5; i++) begin
            strobe2(seq[i]);
        end
        exp_pred2 = 32'hc001_f668;
        for (int r = 0; r < 127; r++) begin
            strobe2(exp_pred2 ^ 32'h1);
            exp_pred2 = ref_next(exp_pred2);
            strobe2(exp_pred2 ^ 32'h1);
            exp_pred2 = ref_next(exp_pred2);
            strobe2(exp_pred2);
            exp_pred2 = ref_next(exp_pred2);
        end
        n_checks++;
        if ({locked2, werr2, berr2} !== {1'b1, 8'hFE, 8'hFE}) begin
            n_fail++;
            $display("FAIL sat_preload: locked=%0b werr=%0h berr=%0h expected 1 fe fe", locked2, werr2, berr2);
        end
        strobe2(exp_pred2 ^ 32'hF);
        exp_pred2 = ref_next(exp_pred2);
        n_checks++;
        if ({werr2, berr2} !== {8'hFF, 8'hFF}) begin
            n_fail++;
            $display("FAIL sat_bit_clamp: werr=%0h berr=%0h expected ff ff", werr2, berr2);
        end
        for (int k = 0; k < 2; k++) begin
            strobe2(exp_pred2);
            exp_pred2 = ref_next(exp_pred2);
            strobe2(exp_pred2 ^ 32'h1);
            exp_pred2 = ref_next(exp_pred2);
        end
        strobe2(exp_pred2);
        exp_pred2 = ref_next(exp_pred2);
        n_checks++;
        if ({locked2, werr2, berr2} !== {1'b1, 8'hFF, 8'hFF}) begin
            n_fail++;
            $display("FAIL sat_hold: locked=%0b werr=%0h berr=%0h expected 1 ff ff", locked2, werr2, berr2);
        end
        @(negedge clk);
        v2    = 1'b1;
        code2 = exp_pred2 ^ 32'h1;
        clr2  = 1'b1;
        @(negedge clk);
        v2    = 1'b0;
        clr2  = 1'b0;
        exp_pred2 = ref_next(exp_pred2);
        n_checks++;
        if ({werr2, berr2, wcnt2} !== '0) begin
            n_fail++;
            $display("FAIL clr_with_err: werr=%0h berr=%0h wcnt=%0d expected 0 0 0", werr2, berr2, wcnt2);
        end
        n_checks++;
        if ({err2, locked2} !== 2'b11) begin
            n_fail++;
            $display("FAIL clr_keeps_pulse: err=%0b locked=%0b expected 1 1", err2, locked2);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time limit, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        seq[0] = 32'h003e_cd12;
        seq[1] = 32'h001f_6689;
        seq[2] = 32'h000f_b344;
        seq[3] = 32'h0007_d9a2;
        seq[4] = 32'h8003_ecd1;
        test_reset();
        test_lock();
        test_zero_error();
        test_unlock_relock();
        test_async_reset();
        test_zero_hunt();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
